// File: rtl/arm_cond_pkg.sv
// rtl/arm_cond_pkg.sv - ARM condition codes, flag indices and E-stage control record
package arm_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic [1:0] flag_w;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [3:0] alu_ctl;
  } ectl_t;

  localparam ectl_t ECTL_BUBBLE = '0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluation against NZCV
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n, w_z, w_c, w_v;
  logic w_base;

  assign w_n = Flags[FLAG_N];
  assign w_z = Flags[FLAG_Z];
  assign w_c = Flags[FLAG_C];
  assign w_v = Flags[FLAG_V];

  // Codes come in pairs; odd code is the complement of the even one, so 1110/1111 give AL/NV.
  always_comb begin
    w_base = 1'b1;
    case (Cond[3:1])
      3'b000:  w_base = w_z;
      3'b001:  w_base = w_c;
      3'b010:  w_base = w_n;
      3'b011:  w_base = w_v;
      3'b100:  w_base = w_c & ~w_z;
      3'b101:  w_base = (w_n == w_v);
      3'b110:  w_base = ~w_z & (w_n == w_v);
      default: w_base = 1'b1;
    endcase
  end

  assign CondEx = w_base ^ Cond[0];

endmodule

// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - ID/EX control register, NZCV flags and condition-gated side effects
module cond_exec_stage
  import arm_cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       Stall,
  input  logic       Flush,
  input  logic [3:0] CondD,
  input  logic [1:0] FlagWD,
  input  logic       PCSD,
  input  logic       RegWD,
  input  logic       MemWD,
  input  logic       MemtoRegD,
  input  logic       ALUSrcD,
  input  logic       BranchD,
  input  logic [3:0] ALUControlD,
  input  logic [3:0] ALUFlags,
  output logic [3:0] ALUControlE,
  output logic       ALUSrcE,
  output logic       MemtoRegE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       PCSrcE,
  output logic       BranchTakenE,
  output logic       CondExE,
  output logic [3:0] Flags
);

  ectl_t      r_e;
  ectl_t      w_d;
  logic [3:0] r_flags;
  logic       w_cond;
  logic       w_cond_ex;

  assign w_d = '{valid: 1'b1, cond: CondD, flag_w: FlagWD, pcs: PCSD, reg_w: RegWD,
                 mem_w: MemWD, mem_to_reg: MemtoRegD, alu_src: ALUSrcD, branch: BranchD,
                 alu_ctl: ALUControlD};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_e <= ECTL_BUBBLE;
    else if (Flush) r_e <= ECTL_BUBBLE;
    else if (!Stall) r_e <= w_d;
  end

  cond_check u_cond_check (
    .Cond   (r_e.cond),
    .Flags  (r_flags),
    .CondEx (w_cond)
  );

  assign w_cond_ex = w_cond & r_e.valid & ~Stall;

  // A flush only affects the next E occupant; the current one still commits its flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (w_cond_ex) begin
      if (r_e.flag_w[1]) begin
        r_flags[FLAG_N] <= ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (r_e.flag_w[0]) begin
        r_flags[FLAG_C] <= ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  assign CondExE      = w_cond_ex;
  assign RegWriteE    = r_e.reg_w  & w_cond_ex;
  assign MemWriteE    = r_e.mem_w  & w_cond_ex;
  assign PCSrcE       = r_e.pcs    & w_cond_ex;
  assign BranchTakenE = r_e.branch & w_cond_ex;
  assign ALUControlE  = r_e.alu_ctl;
  assign ALUSrcE      = r_e.alu_src;
  assign MemtoRegE    = r_e.mem_to_reg;
  assign Flags        = r_flags;

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - directed self-checking bench for cond_exec_stage
module tb_cond_exec_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       Stall, Flush;
  logic [3:0] CondD;
  logic [1:0] FlagWD;
  logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcD, BranchD;
  logic [3:0] ALUControlD, ALUFlags;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, MemtoRegE, RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE;
  logic [3:0] Flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cond_exec_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .CondD(CondD), .FlagWD(FlagWD),
    .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD), .MemtoRegD(MemtoRegD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUFlags(ALUFlags),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
    .BranchTakenE(BranchTakenE), .CondExE(CondExE), .Flags(Flags)
  );

  // gated bundle order: {RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE}
  wire [4:0] gated = {RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE};
  wire [5:0] dctl  = {ALUControlE, ALUSrcE, MemtoRegE};

  task automatic drive_d(input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                         input logic rw, input logic mw, input logic mtr, input logic as,
                         input logic br, input logic [3:0] ac);
    CondD = c; FlagWD = fw; PCSD = pcs; RegWD = rw; MemWD = mw;
    MemtoRegD = mtr; ALUSrcD = as; BranchD = br; ALUControlD = ac;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy & !z;
      4'd9:  return !cy | z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z & (n == v);
      4'd13: return z | (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b0; Stall = 0; Flush = 0; ALUFlags = 0;
    drive_d(4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 4'h0);
    #2;
    checks++; if (gated !== 5'b0) begin failures++; $display("FAIL reset_gated got=%b want=00000", gated); end
    checks++; if (dctl !== 6'b0) begin failures++; $display("FAIL reset_dctl got=%h want=00", dctl); end
    checks++; if (Flags !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", Flags); end
    @(negedge clk); reset = 1'b1;
    drive_d(4'hE, 2'b11, 0, 1, 0, 1, 1, 0, 4'hA);
    step();
    checks++; if (gated !== 5'b10001) begin failures++; $display("FAIL first_load_gated got=%b want=10001", gated); end
    checks++; if (dctl !== {4'hA, 2'b11}) begin failures++; $display("FAIL first_load_dctl got=%h want=2b", dctl); end
    ALUFlags = 4'hF;
    step();
    checks++; if (Flags !== 4'hF) begin failures++; $display("FAIL flags_all_set got=%b want=1111", Flags); end
    #3 reset = 1'b0;
    #1;
    checks++; if (Flags !== 4'h0) begin failures++; $display("FAIL async_reset_flags got=%b want=0000", Flags); end
    checks++; if ({gated, dctl} !== 11'b0) begin failures++; $display("FAIL async_reset_outs got=%b want=0", {gated, dctl}); end
    @(negedge clk); reset = 1'b1; ALUFlags = 4'h0;
    drive_d(4'hE, 2'b00, 0, 1, 0, 0, 0, 0, 4'h0);
    step();
    checks++; if (RegWriteE !== 1'b1) begin failures++; $display("FAIL release_first_load got=%b want=1", RegWriteE); end
  endtask

  task automatic test_cond_exec();
    drive_d(4'hE, 2'b10, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    ALUFlags = 4'b0100;
    drive_d(4'h0, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0);
    step();
    checks++; if (gated !== 5'b01001) begin failures++; $display("FAIL eq_taken got=%b want=01001", gated); end
    drive_d(4'h1, 2'b00, 0, 0, 1, 0, 0, 0, 4'h0);
    step();
    checks++; if (gated !== 5'b00000) begin failures++; $display("FAIL ne_blocked got=%b want=00000", gated); end
  endtask

  task automatic test_split_flags();
    drive_d(4'hE, 2'b11, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    ALUFlags = 4'b0000;
    drive_d(4'hE, 2'b10, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    ALUFlags = 4'b1011;
    drive_d(4'hE, 2'b01, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    checks++; if (Flags !== 4'b1000) begin failures++; $display("FAIL split_nz got=%b want=1000", Flags); end
    ALUFlags = 4'b0111;
    drive_d(4'h0, 2'b11, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    checks++; if (Flags !== 4'b1011) begin failures++; $display("FAIL split_cv got=%b want=1011", Flags); end
    checks++; if (CondExE !== 1'b0) begin failures++; $display("FAIL eq_fails_z0 got=%b want=0", CondExE); end
    ALUFlags = 4'b0100;
    step();
    checks++; if (Flags !== 4'b1011) begin failures++; $display("FAIL failed_cond_flags got=%b want=1011", Flags); end
  endtask

  task automatic test_back_to_back();
    drive_d(4'hE, 2'b11, 0, 0, 0, 0, 0, 0, 4'h0);
    step();
    ALUFlags = 4'b0100;
    drive_d(4'h0, 2'b00, 1, 0, 0, 0, 0, 1, 4'h0);
    step();
    checks++; if (gated !== 5'b00111) begin failures++; $display("FAIL beq_after_cmp got=%b want=00111", gated); end
    checks++; if (Flags !== 4'b0100) begin failures++; $display("FAIL cmp_flags got=%b want=0100", Flags); end
  endtask

  task automatic test_stall_flush();
    drive_d(4'hE, 2'b01, 0, 1, 0, 0, 0, 0, 4'h3);
    step();
    Stall = 1'b1; ALUFlags = 4'b0011;
    drive_d(4'hE, 2'b00, 0, 0, 1, 0, 0, 0, 4'h5);
    #1;
    checks++; if (gated !== 5'b0) begin failures++; $display("FAIL stall1_gated got=%b want=00000", gated); end
    step();
    checks++; if (gated !== 5'b0) begin failures++; $display("FAIL stall2_gated got=%b want=00000", gated); end
    checks++; if (ALUControlE !== 4'h3) begin failures++; $display("FAIL stall_hold_alu got=%h want=3", ALUControlE); end
    checks++; if (Flags !== 4'b0100) begin failures++; $display("FAIL stall_flags got=%b want=0100", Flags); end
    Stall = 1'b0;
    #1;
    checks++; if (gated !== 5'b10001) begin failures++; $display("FAIL stall_release got=%b want=10001", gated); end
    step();
    checks++; if (Flags !== 4'b0111) begin failures++; $display("FAIL post_stall_flags got=%b want=0111", Flags); end
    checks++; if ({gated, ALUControlE} !== {5'b01001, 4'h5}) begin failures++; $display("FAIL next_instr got=%b want=010010101", {gated, ALUControlE}); end
    Stall = 1'b1; Flush = 1'b1;
    step();
    Stall = 1'b0; Flush = 1'b0;
    #1;
    checks++; if ({gated, dctl} !== 11'b0) begin failures++; $display("FAIL flush_over_stall got=%b want=0", {gated, dctl}); end
  endtask

  task automatic test_cond_sweep();
    for (int f = 0; f < 16; f++) begin
      drive_d(4'hE, 2'b11, 0, 0, 0, 0, 0, 0, 4'h0);
      step();
      ALUFlags = f[3:0];
      for (int c = 0; c < 16; c++) begin
        drive_d(c[3:0], 2'b00, 0, 1, 0, 0, 0, 0, 4'h0);
        step();
        checks++;
        if ({CondExE, RegWriteE} !== {2{exp_cond(c[3:0], f[3:0])}}) begin
          failures++;
          $display("FAIL sweep cond=%h flags=%b got=%b want=%b", c[3:0], Flags, {CondExE, RegWriteE},
                   {2{exp_cond(c[3:0], f[3:0])}});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cond_exec();
    test_split_flags();
    test_back_to_back();
    test_stall_flush();
    test_cond_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
